fp_add_arbiter: RTL and testbench
=================================

// Module: fp_add_arbiter
// PURPOSE
//  Shares one FloatingPointAdder instance between NUM_REQ requesters. Each requester uses a valid/ready handshake.
//  The block arbitrates round-robin, registers the winner's operands onto the adder inputs and waits ADD_LAT cycles.
//  It then captures the adder result and returns it, tagged with the requester id, on a single valid/ready response port.
//  One operation is in flight at a time.
// PARAMETERS
//  NUM_REQ  4   number of requesters, 2..8
//  WIDTH    32  operand/result width (IEEE754Single)
//  ADD_LAT  1   cycles operands are held on add_a/add_b before add_result is sampled, 1..15
//  ID_W     $clog2(NUM_REQ) (localparam) width of rsp_id
// PORTS
//  clk        in   1              single clock, rising edge
//  rst_n      in   1              asynchronous active-low reset
//  req_valid  in   NUM_REQ        per-requester operation request
//  req_ready  out  NUM_REQ        per-requester accept, at most one bit high
//  req_a      in   NUM_REQ*WIDTH  operand A; requester i uses bits [i*WIDTH +: WIDTH]
//  req_b      in   NUM_REQ*WIDTH  operand B, same packing as req_a
//  add_a      out  WIDTH          registered operand A to adder input_a
//  add_b      out  WIDTH          registered operand B to adder input_b
//  add_result in   WIDTH          adder result output
//  rsp_valid  out  1              response available
//  rsp_ready  in   1              consumer accepts response
//  rsp_data   out  WIDTH          registered sum
//  rsp_id     out  ID_W           index of the requester that issued the operation
//  busy       out  1              high in every state except IDLE
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, rr_ptr=0, lat_cnt=0, all outputs 0.
//  State machine:
//   IDLE: req_ready = one-hot grant, combinational from req_valid and rr_ptr.
//    Requesters are searched from rr_ptr upward with wrap; the first valid wins.
//    On any req_valid: add_a/add_b <= the winner's operands, rsp_id <= winner,
//     rr_ptr <= winner+1 (wraps NUM_REQ-1 -> 0), lat_cnt <= ADD_LAT-1, -> EXEC.
//    No req_valid: remain in IDLE.
//   EXEC: req_ready=0, add_a/add_b held stable.
//    lat_cnt>0: decrement.
//    lat_cnt==0: rsp_data <= add_result, rsp_valid <= 1, -> RESP.
//   RESP: rsp_valid=1, rsp_data and rsp_id stable until handshake.
//    rsp_valid & rsp_ready: rsp_valid <= 0, -> IDLE.
//    The next grant is no earlier than the following cycle, so there is no IDLE bypass.
//  Latency, handshake in cycle T: rsp_valid is high from T+ADD_LAT+1.
//   Minimum issue interval is ADD_LAT+2 cycles, with rsp_ready held high.
//  Requester rules:
//   A requester may drop req_valid before it is granted; nothing is recorded.
//   Operands are sampled only in the grant cycle.
//  add_a/add_b keep the last operands after the operation; they are not cleared.
//  rsp_ready low in RESP: stall indefinitely, with no new grants and req_ready=0.
//  Reset asserted in any state: in-flight operation discarded, no response emitted, outputs 0 immediately.
//  No arithmetic in this block. rsp_data equals add_result bit-for-bit, including sign/exponent fields.
// TESTING
//  Bench replaces the adder with a stub add_result = add_a + add_b (integer), to check routing only.
//  1) Single op:
//     NUM_REQ=4, ADD_LAT=1, req0 a=0x3F800000 b=0x00000001 valid at T ->
//     req_ready[0]=1 at T; rsp_valid=1 at T+2, rsp_data=0x3F800001, rsp_id=0.
//  2) Round robin: all four valid continuously, rsp_ready=1 ->
//     grant order 0,1,2,3,0; one grant every 3 cycles.
//  3) Backpressure: rsp_ready=0 for 10 cycles in RESP ->
//     rsp_data/rsp_id stable, req_ready=0 throughout, next grant one cycle after rsp_ready=1.
//  4) Latency: ADD_LAT=4, req2 a=5 b=7 ->
//     add_a/add_b stable 4 cycles, rsp_data=12, rsp_id=2, rsp_valid at T+5.
//  5) Wrap and pointer: after a grant to req3, req0 and req2 both valid -> req0 granted first.
//  6) Mid-op reset: rst_n low during EXEC ->
//     outputs 0 asynchronously, no rsp_valid after release, first grant after release goes to req0.

Source files
------------

// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one floating-point adder between NUM_REQ requesters.
// Only one operation is in flight. The winner's operands are registered onto the adder
// inputs and held for ADD_LAT cycles. The adder result is then returned with the
// requester id on a valid/ready response port.
module fp_add_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned ADD_LAT = 1,
    localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [WIDTH-1:0]         add_a,
    output logic [WIDTH-1:0]         add_b,
    input  logic [WIDTH-1:0]         add_result,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_data,
    output logic [ID_W-1:0]          rsp_id,
    output logic                     busy
);

    // ADD_LAT is at most 15, so four bits always hold the countdown.
    localparam int unsigned CntW    = 4;
    localparam logic [CntW-1:0] LatInit = CntW'(ADD_LAT - 1);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e            state_q;
    logic [ID_W-1:0]   rr_ptr_q;
    logic [CntW-1:0]   lat_cnt_q;
    logic [WIDTH-1:0]  add_a_q;
    logic [WIDTH-1:0]  add_b_q;
    logic [WIDTH-1:0]  rsp_data_q;
    logic [ID_W-1:0]   rsp_id_q;
    logic              rsp_valid_q;

    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W-1:0]   grant_next_ptr;
    logic [WIDTH-1:0]  win_a;
    logic [WIDTH-1:0]  win_b;
    int unsigned       cand;

    // Search requesters from rr_ptr upward with wrap; the first valid one wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = (32'(rr_ptr_q) + i) % NUM_REQ;
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(cand);
            end
        end
    end

    // Winner's operands and the pointer value that follows it.
    always_comb begin
        win_a          = req_a[grant_idx*WIDTH +: WIDTH];
        win_b          = req_b[grant_idx*WIDTH +: WIDTH];
        grant_next_ptr = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end

    // One-hot accept, only while idle; forced low during reset so every output reads 0.
    always_comb begin
        req_ready = '0;
        if (rst_n && (state_q == StIdle) && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Control FSM with registered operand, response and id outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            lat_cnt_q   <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (grant_found) begin
                        add_a_q   <= win_a;
                        add_b_q   <= win_b;
                        rsp_id_q  <= grant_idx;
                        rr_ptr_q  <= grant_next_ptr;
                        lat_cnt_q <= LatInit;
                        state_q   <= StExec;
                    end
                end
                StExec: begin
                    if (lat_cnt_q != '0) begin
                        lat_cnt_q <= lat_cnt_q - 1'b1;
                    end else begin
                        rsp_data_q  <= add_result;
                        rsp_valid_q <= 1'b1;
                        state_q     <= StResp;
                    end
                end
                StResp: begin
                    // Return to idle only; the next grant is decided there a cycle later.
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Drive ports from the registered state.
    always_comb begin
        add_a     = add_a_q;
        add_b     = add_b_q;
        rsp_data  = rsp_data_q;
        rsp_id    = rsp_id_q;
        rsp_valid = rsp_valid_q;
        busy      = (state_q != StIdle);
    end

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Bench for fp_add_arbiter with the adder replaced by an integer-add stub.
// dut1 uses ADD_LAT=1 for most sequences; dut4 uses ADD_LAT=4 for the latency case.
module tb_fp_add_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // dut1 signals
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [31:0]  add_a, add_b, add_result;
    logic         rsp_valid, rsp_ready;
    logic [31:0]  rsp_data;
    logic [1:0]   rsp_id;
    logic         busy;

    // dut4 signals
    logic [3:0]   req_valid4;
    logic [3:0]   req_ready4;
    logic [127:0] req_a4;
    logic [127:0] req_b4;
    logic [31:0]  add_a4, add_b4, add_result4;
    logic         rsp_valid4, rsp_ready4;
    logic [31:0]  rsp_data4;
    logic [1:0]   rsp_id4;
    logic         busy4;

    assign add_result  = add_a + add_b;
    assign add_result4 = add_a4 + add_b4;

    fp_add_arbiter #(.NUM_REQ(4), .WIDTH(32), .ADD_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .add_a(add_a), .add_b(add_b),
        .add_result(add_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
    );

    fp_add_arbiter #(.NUM_REQ(4), .WIDTH(32), .ADD_LAT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid4), .req_ready(req_ready4),
        .req_a(req_a4), .req_b(req_b4), .add_a(add_a4), .add_b(add_b4),
        .add_result(add_result4), .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4),
        .rsp_data(rsp_data4), .rsp_id(rsp_id4), .busy(busy4)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   gnt_id_q[$];
    int   gnt_cyc_q[$];

    typedef struct {
        logic [1:0]  id;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: record grants seen on the request side, match responses in order.
    always @(negedge clk) begin
        if (rst_n) begin
            check("ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);
            for (int i = 0; i < 4; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb_q.push_back({2'(i), req_a[i*32 +: 32] + req_b[i*32 +: 32]});
                    gnt_id_q.push_back(i);
                    gnt_cyc_q.push_back(cyc);
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_rsp", 64'(rsp_data), 64'hdead_beef_0000_0000);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("sb_rsp_id", 64'(rsp_id), 64'(e.id));
                    check("sb_rsp_data", 64'(rsp_data), 64'(e.data));
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((busy || sb_q.size() != 0) && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(!busy && sb_q.size() == 0), 64'd1);
        next_cycle();
    endtask

    // One isolated op on dut1: grant at T, response at T+2.
    task automatic run_vec(input vec_t v);
        logic [3:0] oh;
        oh = 4'b0001 << v.id;
        req_a[v.id*32 +: 32] = v.a;
        req_b[v.id*32 +: 32] = v.b;
        req_valid = oh;
        @(negedge clk);
        check("vec_grant", 64'(req_ready), 64'(oh));
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        check("vec_t1_no_rsp", 64'(rsp_valid), 64'd0);
        check("vec_t1_busy", 64'(busy), 64'd1);
        @(negedge clk);
        check("vec_t2_rsp_valid", 64'(rsp_valid), 64'd1);
        check("vec_t2_rsp_data", 64'(rsp_data), 64'(v.exp));
        check("vec_t2_rsp_id", 64'(rsp_id), 64'(v.id));
        next_cycle();
    endtask

    initial begin
        int n;
        logic [31:0] d0;
        logic [1:0]  i0;

        vecs[0] = '{id: 2'd0, a: 32'h3F80_0000, b: 32'h0000_0001, exp: 32'h3F80_0001};
        vecs[1] = '{id: 2'd1, a: 32'hC000_0000, b: 32'h0000_0010, exp: 32'hC000_0010};
        vecs[2] = '{id: 2'd2, a: 32'h7F80_0000, b: 32'h8000_0000, exp: 32'hFF80_0000};
        vecs[3] = '{id: 2'd0, a: 32'hFFFF_FFFF, b: 32'h0000_0001, exp: 32'h0000_0000};
        vecs[4] = '{id: 2'd3, a: 32'h1234_5678, b: 32'h1111_1111, exp: 32'h2345_6789};

        rst_n      = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        rsp_ready  = 1'b1;
        req_valid4 = '0;
        req_a4     = '0;
        req_b4     = '0;
        rsp_ready4 = 1'b1;

        // Reset state
        #3;
        check("rst_add_a", 64'(add_a), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_id", 64'(rsp_id), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        req_valid = 4'hF;
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        req_valid = '0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        next_cycle();
        check("post_rst_idle_ready", 64'(req_ready), 64'd0);
        check("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);

        // Single ops from the vector table
        foreach (vecs[k]) run_vec(vecs[k]);
        drain();

        // Round robin with all requesters valid
        for (int i = 0; i < 4; i++) begin
            req_a[i*32 +: 32] = 32'h100 * (i + 1);
            req_b[i*32 +: 32] = 32'(i + 3);
        end
        gnt_id_q.delete();
        gnt_cyc_q.delete();
        req_valid = 4'hF;
        n = 0;
        while (gnt_id_q.size() < 5 && n < 40) begin
            @(negedge clk);
            n++;
        end
        next_cycle();
        req_valid = '0;
        check("rr_grant_count", 64'(gnt_id_q.size() >= 5), 64'd1);
        if (gnt_id_q.size() >= 5) begin
            int exp_order[5];
            exp_order = '{0, 1, 2, 3, 0};
            for (int k = 0; k < 5; k++) check("rr_order", 64'(gnt_id_q[k]), 64'(exp_order[k]));
            for (int k = 1; k < 5; k++)
                check("rr_interval", 64'(gnt_cyc_q[k] - gnt_cyc_q[k-1]), 64'd3);
        end
        drain();

        // Backpressure in RESP
        req_a[1*32 +: 32] = 32'h4000_0000;
        req_b[1*32 +: 32] = 32'h0040_0000;
        req_a[2*32 +: 32] = 32'h0000_0005;
        req_b[2*32 +: 32] = 32'h0000_0006;
        rsp_ready = 1'b0;
        req_valid = 4'b0110;
        n = 0;
        while (!rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
        check("bp_rsp_id", 64'(rsp_id), 64'd1);
        check("bp_rsp_data", 64'(rsp_data), 64'h4040_0000);
        d0 = rsp_data;
        i0 = rsp_id;
        next_cycle();
        req_valid = 4'b0100;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_hold_valid", 64'(rsp_valid), 64'd1);
            check("bp_hold_data", 64'(rsp_data), 64'(d0));
            check("bp_hold_id", 64'(rsp_id), 64'(i0));
            check("bp_no_ready", 64'(req_ready), 64'd0);
        end
        next_cycle();
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_hs_no_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        check("bp_next_grant", 64'(req_ready), 64'b0100);
        next_cycle();
        req_valid = '0;
        drain();

        // Wrap: after a grant to req3, req0 beats req2
        run_vec('{id: 2'd3, a: 32'h0000_0010, b: 32'h0000_0020, exp: 32'h0000_0030});
        req_a[0*32 +: 32] = 32'h0000_0001;
        req_b[0*32 +: 32] = 32'h0000_0002;
        req_valid = 4'b0101;
        @(negedge clk);
        check("wrap_grant", 64'(req_ready), 64'b0001);
        next_cycle();
        req_valid = '0;
        drain();

        // Latency with ADD_LAT=4 on dut4
        req_a4[2*32 +: 32] = 32'd5;
        req_b4[2*32 +: 32] = 32'd7;
        req_valid4 = 4'b0100;
        @(negedge clk);
        check("lat_grant", 64'(req_ready4), 64'b0100);
        next_cycle();
        req_valid4 = '0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("lat_add_a", 64'(add_a4), 64'd5);
            check("lat_add_b", 64'(add_b4), 64'd7);
            check("lat_no_rsp", 64'(rsp_valid4), 64'd0);
        end
        @(negedge clk);
        check("lat_rsp_valid", 64'(rsp_valid4), 64'd1);
        check("lat_rsp_data", 64'(rsp_data4), 64'd12);
        check("lat_rsp_id", 64'(rsp_id4), 64'd2);
        next_cycle();

        // Mid-op reset during EXEC
        req_a[1*32 +: 32] = 32'h0000_0100;
        req_b[1*32 +: 32] = 32'h0000_0200;
        req_valid = 4'b0010;
        @(negedge clk);
        check("mr_grant", 64'(req_ready), 64'b0010);
        next_cycle();
        req_valid = '0;
        #2 rst_n = 1'b0;
        #1;
        check("mr_add_a", 64'(add_a), 64'd0);
        check("mr_add_b", 64'(add_b), 64'd0);
        check("mr_rsp_valid", 64'(rsp_valid), 64'd0);
        check("mr_rsp_data", 64'(rsp_data), 64'd0);
        check("mr_rsp_id", 64'(rsp_id), 64'd0);
        check("mr_busy", 64'(busy), 64'd0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        sb_q.delete();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("mr_no_rsp", 64'(rsp_valid), 64'd0);
        end
        next_cycle();
        req_a[3*32 +: 32] = 32'h0000_0003;
        req_b[3*32 +: 32] = 32'h0000_0004;
        req_valid = 4'b1001;
        @(negedge clk);
        check("mr_first_grant", 64'(req_ready), 64'b0001);
        next_cycle();
        req_valid = '0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
